epsilon_greedy_router: RTL and testbench



---
 rtl/epsilon_greedy_router_if.sv | 47 ++++
 rtl/epsilon_greedy_router.sv | 263 ++++++++++++++++++++++++++
 tb/tb_epsilon_greedy_router.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/epsilon_greedy_router_if.sv
// epsilon_greedy_router_if
//   Bundles the router's control, RNG handshake and node-RAM signals.
//   Signal prefixes are from the router's point of view (i_ = into the router).
//   slave  : the router itself
//   master : the node FSM / RNG / RAM side (or a testbench)
//   Ports  : i_start, i_mybest, i_bestvalue, i_besthop, i_bestneighbor_id,
//            i_my_node_id, i_eps_step, o_rnd_req, i_rnd_ack, i_rnd_data,
//            o_mem_addr, i_mem_rdata, o_mem_wdata, o_mem_wr, o_nexthop,
//            o_explored, o_which, o_busy, o_done
interface epsilon_greedy_router_if #(
  parameter int WW = 16,
  parameter int AW = 16
);
  logic          i_start;
  logic [WW-1:0] i_mybest;
  logic [WW-1:0] i_bestvalue;
  logic [WW-1:0] i_besthop;
  logic [WW-1:0] i_bestneighbor_id;
  logic [WW-1:0] i_my_node_id;
  logic [WW-1:0] i_eps_step;
  logic          o_rnd_req;
  logic          i_rnd_ack;
  logic [WW-1:0] i_rnd_data;
  logic [AW-1:0] o_mem_addr;
  logic [WW-1:0] i_mem_rdata;
  logic [WW-1:0] o_mem_wdata;
  logic          o_mem_wr;
  logic [WW-1:0] o_nexthop;
  logic          o_explored;
  logic [WW-1:0] o_which;
  logic          o_busy;
  logic          o_done;

  modport slave (
    input  i_start, i_mybest, i_bestvalue, i_besthop, i_bestneighbor_id,
           i_my_node_id, i_eps_step, i_rnd_ack, i_rnd_data, i_mem_rdata,
    output o_rnd_req, o_mem_addr, o_mem_wdata, o_mem_wr, o_nexthop,
           o_explored, o_which, o_busy, o_done
  );

  modport master (
    output i_start, i_mybest, i_bestvalue, i_besthop, i_bestneighbor_id,
           i_my_node_id, i_eps_step, i_rnd_ack, i_rnd_data, i_mem_rdata,
    input  o_rnd_req, o_mem_addr, o_mem_wdata, o_mem_wr, o_nexthop,
           o_explored, o_which, o_busy, o_done
  );
endinterface

// File: rtl/epsilon_greedy_router.sv
// epsilon_greedy_router
//   Epsilon-greedy next-hop selector for the Q-routing node datapath.
//   Explore: uniformly random entry of the better-neighbour table, then decay
//   epsilon in RAM. Exploit: +/-margin hysteresis of bestvalue against mybest.
//   Ports: clock (rising edge), nrst (synchronous, active low),
//          bus (epsilon_greedy_router_if.slave; see interface header).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_RNG_E  | waiting for random word used for the explore decision
//   S_RD_EPS | reading epsilon (phase 0: address out, phase 1: data in)
//   S_RNG_W  | waiting for random word and neighbour count
//   S_MOD    | restoring division, one quotient bit per cycle
//   S_RD_NBR | reading table[which] (phase 0 / phase 1 as in S_RD_EPS)
//   S_WR_EPS | one-cycle write of decayed epsilon
//   S_CMP    | hysteresis compare (phase 0: compare, phase 1: select)
//   S_DONE   | done pulse, results held
module epsilon_greedy_router #(
  parameter int          WORD_WIDTH   = 16,
  parameter int          FRAC_BITS    = 5,
  parameter int          ADDR_WIDTH   = 16,
  parameter int          RND_BITS     = 4,
  parameter int          MAX_NBR      = 16,
  parameter int unsigned EPS_ADDR     = 'h0004,
  parameter int unsigned CNT_ADDR     = 'h068C,
  parameter int unsigned NBR_BASE     = 'h0668,
  parameter int unsigned MARGIN_Q16   = 'd66,
  parameter int          DECAY_MODE   = 0,
  parameter int unsigned EPS_MULT     = 'hF333,
  parameter int unsigned NEXTHOP_NONE = 'd301
) (
  input logic                    clock,
  input logic                    nrst,
  epsilon_greedy_router_if.slave bus
);
  localparam int WW  = WORD_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int CW  = 2 * WW + 2;
  localparam int BCW = $clog2(WW + 1);
  localparam int unsigned LO_MUL = 32'd65536 - MARGIN_Q16;
  localparam int unsigned HI_MUL = 32'd65536 + MARGIN_Q16;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RNG_E  = 4'd1;
  localparam logic [3:0] S_RD_EPS = 4'd2;
  localparam logic [3:0] S_RNG_W  = 4'd3;
  localparam logic [3:0] S_MOD    = 4'd4;
  localparam logic [3:0] S_RD_NBR = 4'd5;
  localparam logic [3:0] S_WR_EPS = 4'd6;
  localparam logic [3:0] S_CMP    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  // Fraction bits cancel out of the scale-free compare; only sanity-checked.
  if (FRAC_BITS >= WORD_WIDTH || RND_BITS > WORD_WIDTH || WORD_WIDTH < 16) begin : g_param_check
    $error("epsilon_greedy_router: unsupported parameter combination");
  end

  logic [3:0]          r_state;
  logic                r_phase;
  logic [RND_BITS-1:0] r_x;
  logic [WW-1:0]       r_eps;
  logic                r_r_got;
  logic [WW-1:0]       r_r;
  logic [WW-1:0]       r_cnt;
  logic [WW-1:0]       r_rem;
  logic [BCW-1:0]      r_bit_cnt;
  logic                r_lt_lo;
  logic                r_lt_hi;
  logic                r_id_ne;

  logic                r_rnd_req;
  logic [AW-1:0]       r_mem_addr;
  logic [WW-1:0]       r_mem_wdata;
  logic                r_mem_wr;
  logic [WW-1:0]       r_nexthop;
  logic                r_explored;
  logic [WW-1:0]       r_which;
  logic                r_busy;
  logic                r_done;

  logic                w_rnd_take;
  logic [WW-1:0]       w_r_now;
  logic [WW-1:0]       w_cnt_clamp;
  logic [WW:0]         w_rem_sh;
  logic                w_rem_ge;
  logic [WW-1:0]       w_rem_next;
  logic [AW-1:0]       w_nbr_addr;
  logic [WW-1:0]       w_eps_lin;
  logic [2*WW-1:0]     w_prod;
  logic [WW-1:0]       w_eps_mul;
  logic [WW-1:0]       w_eps_new;
  logic [CW-1:0]       w_cmp_l;
  logic [CW-1:0]       w_cmp_lo;
  logic [CW-1:0]       w_cmp_hi;

  assign w_rnd_take  = bus.i_rnd_ack & r_rnd_req;
  // The random word may have been accepted before the count read settled.
  assign w_r_now     = r_r_got ? r_r : bus.i_rnd_data;
  assign w_cnt_clamp = (bus.i_mem_rdata > WW'(MAX_NBR)) ? WW'(MAX_NBR) : bus.i_mem_rdata;

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh    = {r_rem, r_r[WW-1]};
  assign w_rem_ge    = (w_rem_sh >= {1'b0, r_cnt});
  assign w_rem_next  = w_rem_ge ? WW'(w_rem_sh - {1'b0, r_cnt}) : w_rem_sh[WW-1:0];
  assign w_nbr_addr  = AW'(NBR_BASE) + AW'({w_rem_next, 1'b0});

  assign w_eps_lin   = (r_eps < bus.i_eps_step) ? '0 : (r_eps - bus.i_eps_step);
  assign w_prod      = {{WW{1'b0}}, r_eps} * (2 * WW)'(EPS_MULT);
  assign w_eps_mul   = WW'(w_prod >> 16);
  assign w_eps_new   = (DECAY_MODE == 0) ? w_eps_lin : w_eps_mul;

  // Widened so neither margin product can overflow.
  assign w_cmp_l     = CW'(bus.i_bestvalue) << 16;
  assign w_cmp_lo    = CW'(bus.i_mybest) * CW'(LO_MUL);
  assign w_cmp_hi    = CW'(bus.i_mybest) * CW'(HI_MUL);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_x         <= '0;
      r_eps       <= '0;
      r_r_got     <= 1'b0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_bit_cnt   <= '0;
      r_lt_lo     <= 1'b0;
      r_lt_hi     <= 1'b0;
      r_id_ne     <= 1'b0;
      r_rnd_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_nexthop   <= WW'(NEXTHOP_NONE);
      r_explored  <= 1'b0;
      r_which     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_busy     <= 1'b1;
            r_nexthop  <= WW'(NEXTHOP_NONE);
            r_explored <= 1'b0;
            r_rnd_req  <= 1'b1;
            r_state    <= S_RNG_E;
          end
        end
        S_RNG_E: begin
          if (bus.i_rnd_ack) begin
            r_x        <= bus.i_rnd_data[RND_BITS-1:0];
            r_rnd_req  <= 1'b0;
            r_mem_addr <= AW'(EPS_ADDR);
            r_phase    <= 1'b0;
            r_state    <= S_RD_EPS;
          end
        end
        S_RD_EPS: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_eps   <= bus.i_mem_rdata;
            r_phase <= 1'b0;
            if (WW'(r_x) < bus.i_mem_rdata) begin
              r_rnd_req  <= 1'b1;
              r_r_got    <= 1'b0;
              r_mem_addr <= AW'(CNT_ADDR);
              r_state    <= S_RNG_W;
            end else begin
              r_state <= S_CMP;
            end
          end
        end
        S_RNG_W: begin
          if (w_rnd_take) begin
            r_r       <= bus.i_rnd_data;
            r_r_got   <= 1'b1;
            r_rnd_req <= 1'b0;
          end
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else if (r_r_got || w_rnd_take) begin
            r_cnt   <= w_cnt_clamp;
            r_phase <= 1'b0;
            if (w_cnt_clamp == '0) begin
              r_state <= S_CMP;
            end else begin
              r_r       <= w_r_now;
              r_rem     <= '0;
              r_bit_cnt <= BCW'(WW);
              r_state   <= S_MOD;
            end
          end
        end
        S_MOD: begin
          r_rem     <= w_rem_next;
          r_r       <= r_r << 1;
          r_bit_cnt <= r_bit_cnt - BCW'(1);
          if (r_bit_cnt == BCW'(1)) begin
            r_which    <= w_rem_next;
            r_mem_addr <= w_nbr_addr;
            r_phase    <= 1'b0;
            r_state    <= S_RD_NBR;
          end
        end
        S_RD_NBR: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_nexthop   <= bus.i_mem_rdata;
            r_explored  <= 1'b1;
            r_mem_addr  <= AW'(EPS_ADDR);
            r_mem_wdata <= w_eps_new;
            r_mem_wr    <= 1'b1;
            r_phase     <= 1'b0;
            r_state     <= S_WR_EPS;
          end
        end
        S_WR_EPS: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_CMP: begin
          if (!r_phase) begin
            r_lt_lo <= (w_cmp_l < w_cmp_lo);
            r_lt_hi <= (w_cmp_l < w_cmp_hi);
            r_id_ne <= (bus.i_bestneighbor_id != bus.i_my_node_id);
            r_phase <= 1'b1;
          end else begin
            // Inside the band only switch when the best neighbour is not us.
            r_nexthop <= (r_lt_lo || (r_lt_hi && r_id_ne)) ? bus.i_besthop : WW'(NEXTHOP_NONE);
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_phase   <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rnd_req   = r_rnd_req;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_mem_wr    = r_mem_wr;
  assign bus.o_nexthop   = r_nexthop;
  assign bus.o_explored  = r_explored;
  assign bus.o_which     = r_which;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_epsilon_greedy_router.sv
// tb_epsilon_greedy_router
//   Drives two router instances (linear and multiplicative decay) from the
//   same stimulus, RNG and RAM model; checks results against a reference
//   model through a scoreboard queue popped on each done pulse.
module tb_epsilon_greedy_router;
  localparam int WW       = 16;
  localparam int AW       = 16;
  localparam int NONE     = 301;
  localparam int EPS_A    = 'h0004;
  localparam int CNT_A    = 'h068C;
  localparam int NBR_A    = 'h0668;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  always #5 clock = ~clock;

  epsilon_greedy_router_if #(.WW(WW), .AW(AW)) bus ();
  epsilon_greedy_router_if #(.WW(WW), .AW(AW)) bus_m1 ();

  epsilon_greedy_router #(.DECAY_MODE(0)) dut (
    .clock(clock), .nrst(nrst), .bus(bus.slave)
  );
  epsilon_greedy_router #(.DECAY_MODE(1)) dut_m1 (
    .clock(clock), .nrst(nrst), .bus(bus_m1.slave)
  );

  assign bus_m1.i_start           = bus.i_start;
  assign bus_m1.i_mybest          = bus.i_mybest;
  assign bus_m1.i_bestvalue       = bus.i_bestvalue;
  assign bus_m1.i_besthop         = bus.i_besthop;
  assign bus_m1.i_bestneighbor_id = bus.i_bestneighbor_id;
  assign bus_m1.i_my_node_id      = bus.i_my_node_id;
  assign bus_m1.i_eps_step        = bus.i_eps_step;
  assign bus_m1.i_rnd_ack         = bus.i_rnd_ack;
  assign bus_m1.i_rnd_data        = bus.i_rnd_data;
  assign bus_m1.i_mem_rdata       = bus.i_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Node RAM: synchronous read, data one cycle after the address.
  logic [15:0] ram [0:65535];
  always @(posedge clock) bus.i_mem_rdata <= ram[bus.o_mem_addr];

  // RNG: answers each request after 0..max_dly cycles with a one-cycle ack.
  int rng_q[$];
  int rng_dly = 0;
  int max_dly = 3;
  always @(negedge clock) begin
    if (!nrst) begin
      bus.i_rnd_ack = 1'b0;
      rng_dly = 0;
    end else if (bus.i_rnd_ack) begin
      bus.i_rnd_ack = 1'b0;
    end else if (bus.o_rnd_req) begin
      if (rng_dly > 0) rng_dly--;
      else begin
        bus.i_rnd_ack  = 1'b1;
        bus.i_rnd_data = (rng_q.size() > 0) ? 16'(rng_q.pop_front()) : 16'($urandom);
        rng_dly = $urandom_range(0, max_dly);
      end
    end
  end

  typedef struct {
    int nexthop;
    bit explored;
    int which;
    int n_wr;
    int wd0;
    int wd1;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: collects RAM writes and checks each completed decision.
  int   wr_cnt = 0;
  int   wd0_seen, wd1_seen, wa_seen;
  exp_t mon_e;
  always @(negedge clock) begin
    if (nrst) begin
      if (bus.o_mem_wr) begin
        wr_cnt++;
        wd0_seen = int'(bus.o_mem_wdata);
        wd1_seen = int'(bus_m1.o_mem_wdata);
        wa_seen  = int'(bus.o_mem_addr);
      end
      if (bus.o_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("nexthop", bus.o_nexthop, mon_e.nexthop);
          chk("nexthop_m1", bus_m1.o_nexthop, mon_e.nexthop);
          chk("explored", bus.o_explored, mon_e.explored);
          chk("busy_at_done", bus.o_busy, 0);
          if (mon_e.explored) chk("which", bus.o_which, mon_e.which);
          chk("mem_wr_count", wr_cnt, mon_e.n_wr);
          if (mon_e.n_wr > 0 && wr_cnt > 0) begin
            chk("wr_addr", wa_seen, EPS_A);
            chk("wdata_linear", wd0_seen, mon_e.wd0);
            chk("wdata_mult", wd1_seen, mon_e.wd1);
          end
        end
        wr_cnt = 0;
      end
    end
  end

  function automatic int exploit_hop(int mb, int bv, int bh, int bid, int myid);
    longint l, lo, hi;
    l  = longint'(bv) * 65536;
    lo = longint'(mb) * (65536 - 66);
    hi = longint'(mb) * (65536 + 66);
    if (l < lo || (l < hi && bid != myid)) return bh;
    return NONE;
  endfunction

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
  endtask

  task automatic decide(input int eps, input int x, input int cnt, input int r, input int step,
                        input int mb, input int bv, input int bh, input int bid, input int myid,
                        input bit extra);
    exp_t e;
    int   c;
    bit   seen;
    ram[EPS_A] = 16'(eps);
    ram[CNT_A] = 16'(cnt);
    e.explored = 0; e.which = 0; e.n_wr = 0; e.wd0 = 0; e.wd1 = 0;
    e.nexthop  = exploit_hop(mb, bv, bh, bid, myid);
    c = (cnt > 16) ? 16 : cnt;
    if (x < eps && c > 0) begin
      e.explored = 1;
      e.which    = r % c;
      e.nexthop  = int'(ram[NBR_A + 2 * e.which]);
      e.n_wr     = 1;
      e.wd0      = (eps < step) ? 0 : eps - step;
      e.wd1      = (eps * 'hF333) / 65536;
    end
    rng_q.delete();
    rng_q.push_back(int'($urandom_range(0, 4095)) * 16 + x);
    rng_q.push_back(r);
    @(negedge clock);
    bus.i_mybest = 16'(mb); bus.i_bestvalue = 16'(bv); bus.i_besthop = 16'(bh);
    bus.i_bestneighbor_id = 16'(bid); bus.i_my_node_id = 16'(myid); bus.i_eps_step = 16'(step);
    exp_q.push_back(e);
    pulse_start();
    if (extra) begin
      @(negedge clock);
      pulse_start();
      pulse_start();
    end
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      if (bus.o_done) begin seen = 1; break; end
      @(negedge clock);
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      nrst = 1'b0;
      repeat (2) @(negedge clock);
      nrst = 1'b1;
    end
    repeat (3) @(negedge clock);
    chk("idle_after_done", bus.o_busy, 0);
  endtask

  initial begin
    int mb, bv, sel, eps, x;
    bus.i_start = 0; bus.i_mybest = 0; bus.i_bestvalue = 0; bus.i_besthop = 0;
    bus.i_bestneighbor_id = 0; bus.i_my_node_id = 0; bus.i_eps_step = 0;
    bus.i_rnd_ack = 0; bus.i_rnd_data = 0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
    for (int i = 0; i < 16; i++) ram[NBR_A + 2 * i] = 16'($urandom_range(0, 300));

    nrst = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_nexthop", bus.o_nexthop, NONE);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_rnd_req", bus.o_rnd_req, 0);
    chk("rst_mem_wr", bus.o_mem_wr, 0);
    chk("rst_explored", bus.o_explored, 0);
    chk("rst_which", bus.o_which, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    nrst = 1'b1;
    @(negedge clock);

    // Exploit switch, hysteresis band both ways.
    decide(0, 5, 3, 0, 1, 100, 50, 7, 1, 2, 0);
    decide(0, 9, 3, 0, 1, 3200, 3200, 11, 3, 4, 0);
    decide(0, 9, 3, 0, 1, 3200, 3200, 11, 4, 4, 0);
    // Explore with modulo selection and linear decay.
    ram[NBR_A + 4] = 16'd9;
    decide(10, 3, 5, 37, 4, 100, 50, 7, 1, 2, 0);
    // Decay edges: linear saturation, multiplicative 15 -> 14.
    decide(2, 0, 3, 1000, 5, 100, 200, 7, 1, 2, 0);
    decide(15, 0, 3, 77, 1, 100, 200, 7, 1, 2, 0);
    // Empty table falls back to exploit; oversize count clamps.
    decide(10, 0, 0, 5, 1, 100, 50, 21, 1, 2, 0);
    decide(10, 0, 40, 20, 1, 100, 50, 21, 1, 2, 0);

    // Reset while dividing: no write, result returns to "none".
    max_dly = 0;
    ram[EPS_A] = 16'd10; ram[CNT_A] = 16'd5;
    rng_q.delete(); rng_q.push_back(1); rng_q.push_back(12345);
    @(negedge clock);
    pulse_start();
    repeat (10) @(negedge clock);
    chk("busy_before_reset", bus.o_busy, 1);
    nrst = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_nexthop", bus.o_nexthop, NONE);
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_no_write", wr_cnt, 0);
    nrst = 1'b1;
    wr_cnt = 0;
    repeat (30) @(negedge clock);
    chk("abort_no_done", bus.o_busy | bus.o_done, 0);
    chk("abort_no_write_after", wr_cnt, 0);
    max_dly = 3;

    // Randomized mix.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) ram[NBR_A + 2 * i] = 16'($urandom_range(0, 300));
      mb  = int'($urandom_range(0, 65535));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: bv = int'($urandom_range(0, 65535));
        1: bv = mb;
        2: bv = (mb > 0) ? mb - 1 : 0;
        default: bv = (mb < 65533) ? mb + int'($urandom_range(0, 2)) : mb;
      endcase
      eps = int'($urandom_range(0, 16));
      x   = int'($urandom_range(0, 15));
      decide(eps, x, int'($urandom_range(0, 40)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 20)), mb, bv, int'($urandom_range(0, 300)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 1)) * 2,
             (x < eps) && ($urandom_range(0, 1) == 1));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
